// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier (MULT/MULTU) with start/busy/done handshake.
// Define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier is zero.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           op,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam logic [5:0] OP_MULT  = 6'd24;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam int         CW       = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]     r_mplr;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_signed;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH-1:0]     w_mplr_sh;
    logic [2*WIDTH-1:0]   w_prod_nx;
    logic                 w_last;

    assign w_accept  = (r_state == S_IDLE) && start &&
                       ((op == OP_MULT) || (op == OP_MULTU));
    assign w_signed  = (op == OP_MULT);
    // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is correct unsigned
    assign w_mag_a   = (w_signed && dataA[WIDTH-1]) ? -dataA : dataA;
    assign w_mag_b   = (w_signed && dataB[WIDTH-1]) ? -dataB : dataB;
    assign w_mplr_sh = r_mplr >> 1;
    assign w_prod_nx = r_mplr[0] ? (r_prod + r_mcand) : r_prod;

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(1)) || (w_mplr_sh == '0);
`else
    assign w_last = (r_cnt == CW'(1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_out   <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplr  <= w_mag_b;
                        r_prod  <= '0;
                        r_cnt   <= CW'(WIDTH);
                        r_neg   <= w_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_prod  <= w_prod_nx;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= w_mplr_sh;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_out  <= r_neg ? (~r_prod + 1'b1) : r_prod;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_out;
    assign hi      = r_out[2*WIDTH-1:WIDTH];
    assign lo      = r_out[WIDTH-1:0];

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier for the execute-stage HI/LO path. It supports both signed (MULT) and unsigned (MULTU) operation and runs from a start/busy/done handshake, so the controller no longer sequences each iteration. The full 2·WIDTH-bit product is captured into a result register that feeds HI/LO. The block is the generalised successor of the fixed 32-bit, unsigned-only, controller-stepped multiplier.

## Interface
- WIDTH, 32: operand width in bits; the product is 2·WIDTH bits; WIDTH must be 4 or greater.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  6  operation code: 6'd24 = MULT (signed), 6'd25 = MULTU (unsigned). Any other value with start is ignored.
- dataA  input  WIDTH  multiplicand; sampled on the accepting edge.
- dataB  input  WIDTH  multiplier; sampled on the accepting edge.
- busy  output  1  high while an operation is in flight (RUN or FIX).
- done  output  1  one-cycle pulse; the result is valid from this cycle onward.
- dataOut  output  2·WIDTH  result register, {HI, LO}.
- hi  output  WIDTH  dataOut[2·WIDTH-1:WIDTH].
- lo  output  WIDTH  dataOut[WIDTH-1:0].

## Operation
- States:
  - IDLE → RUN on an accepted start.
  - RUN → FIX when the iteration count is exhausted.
  - FIX → IDLE unconditionally.
- Acceptance condition: state is IDLE, start is 1, and op is 24 or 25.
- On acceptance:
  - mcand (2·WIDTH bits) ← zero-extended operand magnitude.
  - mplr (WIDTH bits) ← operand magnitude.
  - prod ← 0.
  - cnt ← WIDTH.
  - neg ← dataA[MSB] ^ dataB[MSB] for MULT; neg ← 0 for MULTU.
- Operand magnitude:
  - MULT: two's-complement absolute value, taken as unsigned.
  - MULTU: raw operand.
  - The magnitude of the most-negative value is 2^(WIDTH-1). This fits as unsigned, so no overflow handling is needed.
- Each RUN cycle:
  - if mplr[0], prod ← prod + mcand (2·WIDTH-bit add, no carry-out needed);
  - mcand shifts left 1 with zero fill;
  - mplr shifts right 1 with zero fill;
  - cnt decrements.
- Leave RUN after the iteration in which cnt goes from 1 to 0.
- FIX cycle:
  - dataOut ← neg ? (~prod + 1) : prod;
  - done ← 1 on the following cycle, for exactly one cycle.
- dataOut holds its value until the next FIX. It does not change on an ignored start or during RUN.
- start while busy is ignored and has no side effects. start with an invalid op is ignored.
- Asynchronous reset, at any time including mid-operation:
  - state → IDLE;
  - busy, done, dataOut, prod, mcand, mplr, cnt, neg → 0;
  - the aborted operation produces no done.

## Timing
- Let edge E0 be the edge that accepts start.
- busy is 1 from after E0 through the cycle before done.
- RUN occupies edges E1 to E_WIDTH. FIX occupies edge E_WIDTH+1.
- After edge E_WIDTH+1, the registers read:
  - dataOut = result;
  - done = 1;
  - busy = 0;
  - state = IDLE.
- Latency from the accepting edge to done/result: WIDTH+1 cycles; 33 for WIDTH = 32.
- Back-to-back: a start presented in the done cycle is accepted at E_WIDTH+2. There is no dead cycle.
- done and busy are never high at the same time.
- All outputs are registered.

## Configuration
- MUL_EARLY_TERM_EN:
  - When defined, RUN also exits to FIX after any iteration whose shifted mplr is zero.
  - At least one RUN iteration always occurs.
  - Latency = max(1, index of highest set bit of |dataB| + 1) + 1 cycles.
  - Results are bit-identical to the non-early-terminating case.
- When not defined: fixed latency of WIDTH+1 cycles regardless of operands.

## Test plan
- **Unsigned maximum:** WIDTH 32, MULTU, 0xFFFFFFFF × 0xFFFFFFFF → dataOut = 0xFFFFFFFE_00000001; done exactly 33 cycles after the accepting edge; busy low in the done cycle.
- **Signed mixed sign:** MULT, 0xFFFFFFFF (−1) × 0x00000002 → 0xFFFFFFFF_FFFFFFFE; hi = 0xFFFFFFFF; lo = 0xFFFFFFFE.
- **Signed most-negative:** MULT, 0x80000000 × 0x80000000 → 0x40000000_00000000. MULTU on the same operands → 0x40000000_00000000.
- **Ignored and back-to-back starts:**
  - Start MULTU 3 × 5.
  - Pulse start with 9 × 9 at cycle 10 → ignored; result is 15.
  - Start 7 × 6 in the done cycle → accepted; result 42 after a further 33 cycles.
- **Reset mid-operation:**
  - Assert reset low at cycle 12 of MULT 0x1234 × 0x5678 → dataOut, busy and done are 0 immediately (asynchronous).
  - Release, then run MULTU 0x10 × 0x10 → 0x100; no stale done.
- **Early termination (MUL_EARLY_TERM_EN defined):** MULTU 7 × 3 → 21 with done 3 cycles after acceptance. The same stimulus without the macro gives done at 33.
